// File: rtl/ssc_tx_capture_pkg.sv
// Shared types and constants for the SSC transmit-line capture block.
package ssc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } ssc_rx_state_t;

  localparam int         SSC_OVERSAMPLE = 16;
  localparam logic [3:0] SSC_SMP_A      = 4'd7;
  localparam logic [3:0] SSC_SMP_B      = 4'd8;
  localparam logic [3:0] SSC_SMP_C      = 4'd9;

  // 2-of-3 vote used to de-glitch each bit sample
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ssc_tx_capture_if.sv
// Byte stream (valid/ready) carrying recovered bytes to the consumer.
interface ssc_tx_capture_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, m_valid, input  m_ready);
  modport slave  (input  m_data, m_valid, output m_ready);
endinterface

// File: rtl/ssc_tx_capture_byte_fifo.sv
// First-word-fall-through byte FIFO; extra pointer MSB separates full from empty.
module ssc_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_logic,
  input  logic       system_reset_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en   = push_i && (!full_o || rd_en);
  // head is forced to zero when empty so the output is defined out of reset
  assign data_o  = empty_o ? 8'h00 : mem_q[rptr_q[AW-1:0]];

  // pointer update
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
      if (rd_en) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // storage write
  always_ff @(posedge clk_logic) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ssc_tx_capture.sv
// 8-N-1 capture of the SSC TX line: sync, 16x oversample, byte FIFO, stream out.
// Optional: define SSC_TX_CAPTURE_BREAK_EN to detect line breaks (break_o).
module ssc_tx_capture
  import ssc_pkg::*;
#(
  parameter int CLK_HZ     = 54_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_logic,
  input  logic              system_reset_n,
  input  logic              serial_i,
  ssc_tx_capture_if.master  m_if,
  output logic              frame_err_o,
  output logic              break_o,
  output logic              overflow_o,
  input  logic              ovf_clr_i
);
  localparam int DIV = (CLK_HZ + (SSC_OVERSAMPLE * BAUD) / 2) / (SSC_OVERSAMPLE * BAUD) - 1;
  localparam int DW  = (DIV > 0) ? $clog2(DIV + 1) : 1;

  ssc_rx_state_t state_q, state_d;
  logic          sync1_q, sync2_q, prev_q, fall;
  logic [DW-1:0] div_q;
  logic          tick, div_clr, mid, bit_val;
  logic [3:0]    scnt_q, scnt_d, scnt_nxt, hcnt_q;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          m7_q, m7_d, m8_q, m8_d;
  logic          armed_q, push_q, push_d, ferr_q, ferr_d, ovf_q;
  logic          full, empty, pop;

  assign fall     = prev_q & ~sync2_q;
  assign tick     = (div_q == DW'(DIV));
  assign scnt_nxt = scnt_q + 4'd1;
  assign mid      = tick && (scnt_nxt == SSC_SMP_C);
  assign bit_val  = maj3(m7_q, m8_q, sync2_q);

  // line synchronizer and edge history, all idle-high
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // free-running 16x tick divider, realigned on each accepted start edge
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n)  div_q <= '0;
    else if (div_clr || tick) div_q <= '0;
    else                  div_q <= div_q + DW'(1);
  end

  // after reset, ignore start edges until the line has been high for a full bit
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      hcnt_q  <= '0;
      armed_q <= 1'b0;
    end else if (!armed_q) begin
      if (!sync2_q) hcnt_q <= '0;
      else if (tick) begin
        hcnt_q <= hcnt_q + 4'd1;
        if (hcnt_q == 4'd15) armed_q <= 1'b1;
      end
    end
  end

  // receiver state and datapath registers
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      m7_q    <= 1'b1;
      m8_q    <= 1'b1;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      m7_q    <= m7_d;
      m8_q    <= m8_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef SSC_TX_CAPTURE_BREAK_EN
  logic rise, brk_d, brk_q;
  assign rise    = ~prev_q & sync2_q;
  assign break_o = brk_q;

  // break pulse register
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) brk_q <= 1'b0;
    else                 brk_q <= brk_d;
  end
`else
  assign break_o = 1'b0;
`endif

  // next-state: bit sampling, framing decisions and push/error requests
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    m7_d    = m7_q;
    m8_d    = m8_q;
    div_clr = 1'b0;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef SSC_TX_CAPTURE_BREAK_EN
    brk_d   = 1'b0;
`endif
    if (tick) begin
      scnt_d = scnt_nxt;
      if (scnt_nxt == SSC_SMP_A) m7_d = sync2_q;
      if (scnt_nxt == SSC_SMP_B) m8_d = sync2_q;
    end
    unique case (state_q)
      IDLE: if (fall && armed_q) begin
        state_d = START;
        scnt_d  = '0;
        div_clr = 1'b1;
      end
      START: if (mid) state_d = bit_val ? IDLE : DATA;
      DATA: if (mid) begin
        shreg_d = {bit_val, shreg_q[7:1]};
        bcnt_d  = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = STOP;
      end
      STOP: if (mid) begin
        // back to IDLE at the stop midpoint so a following start edge is caught
        state_d = IDLE;
        if (bit_val) push_d = 1'b1;
`ifdef SSC_TX_CAPTURE_BREAK_EN
        else if (shreg_q == 8'h00) state_d = BREAK;
`endif
        else ferr_d = 1'b1;
      end
`ifdef SSC_TX_CAPTURE_BREAK_EN
      BREAK: if (rise) begin
        brk_d   = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign pop         = m_if.m_valid && m_if.m_ready;
  assign m_if.m_valid = !empty;
  assign frame_err_o = ferr_q;
  assign overflow_o  = ovf_q;

  // sticky overflow: a dropped byte wins over a same-cycle clear
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n)              ovf_q <= 1'b0;
    else if (push_q && full && !pop)  ovf_q <= 1'b1;
    else if (ovf_clr_i)               ovf_q <= 1'b0;
  end

  ssc_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_logic      (clk_logic),
    .system_reset_n (system_reset_n),
    .push_i         (push_q),
    .data_i         (shreg_q),
    .pop_i          (pop),
    .data_o         (m_if.m_data),
    .full_o         (full),
    .empty_o        (empty)
  );

endmodule

// File: tb/tb_ssc_tx_capture.sv
// Directed bench for ssc_tx_capture at 16 x 4 clocks per bit.
module tb_ssc_tx_capture;
  localparam int BIT = 64;
`ifdef SSC_TX_CAPTURE_BREAK_EN
  localparam int BRK_EN = 1;
`else
  localparam int BRK_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, serial, ovf_clr, frame_err, brk, ovf;
  int   errors = 0, checks = 0;
  int   ferr_cnt = 0, brk_cnt = 0, f0, b0;
  logic [7:0] got[$];

  ssc_tx_capture_if sif();

  ssc_tx_capture #(.CLK_HZ(614_400), .BAUD(9600), .FIFO_DEPTH(16)) dut (
    .clk_logic      (clk),
    .system_reset_n (rst_n),
    .serial_i       (serial),
    .m_if           (sif),
    .frame_err_o    (frame_err),
    .break_o        (brk),
    .overflow_o     (ovf),
    .ovf_clr_i      (ovf_clr)
  );

  always #5 clk = ~clk;

  // collect transfers and pulse counts away from the active edge
  always @(negedge clk) begin
    if (sif.m_valid && sif.m_ready) got.push_back(sif.m_data);
    if (frame_err) ferr_cnt++;
    if (brk) brk_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    serial = 1'b0; idle(BIT);
    for (int i = 0; i < 8; i++) begin serial = b[i]; idle(BIT); end
    serial = stop; idle(BIT);
    serial = 1'b1;
  endtask

  function automatic logic [8:0] pop_got();
    if (got.size() == 0) return 9'h1FF;
    return {1'b0, got.pop_front()};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(sif.m_valid), 0);
    chk({tag, "_data"},  32'(sif.m_data), 0);
    chk({tag, "_ferr"},  32'(frame_err), 0);
    chk({tag, "_brk"},   32'(brk), 0);
    chk({tag, "_ovf"},   32'(ovf), 0);
  endtask

  initial begin
    logic [7:0] part;
    serial = 1'b1; sif.m_ready = 1'b0; ovf_clr = 1'b0; rst_n = 1'b0;
    idle(4);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(2 * BIT);

    // back-to-back frames
    sif.m_ready = 1'b1;
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    idle(2 * BIT);
    chk("b2b_cnt", got.size(), 2);
    chk("b2b_0", pop_got(), 9'h055);
    chk("b2b_1", pop_got(), 9'h0A3);
    chk("b2b_ferr", ferr_cnt, 0);
    chk("b2b_brk", brk_cnt, 0);

    // one-tick glitch is a false start; next frame still clean
    serial = 1'b0; idle(4); serial = 1'b1;
    idle(3 * BIT);
    chk("glitch_nobyte", got.size(), 0);
    chk("glitch_ferr", ferr_cnt, 0);
    send_byte(8'h3C, 1'b1);
    idle(BIT);
    chk("post_glitch", pop_got(), 9'h03C);

    // bad stop bit
    f0 = ferr_cnt;
    send_byte(8'h41, 1'b0);
    idle(2 * BIT);
    chk("ferr_pulse", ferr_cnt - f0, 1);
    chk("ferr_nobyte", got.size(), 0);
    chk("ferr_empty", 32'(sif.m_valid), 0);

    // overflow: 17 bytes into 16 entries
    sif.m_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    idle(BIT);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_valid", 32'(sif.m_valid), 1);
    chk("ovf_head", 32'(sif.m_data), 0);
    sif.m_ready = 1'b1;
    idle(24);
    chk("drain_cnt", got.size(), 16);
    for (int i = 0; i < 16; i++) chk("drain_byte", pop_got(), 32'(i));
    chk("drain_empty", 32'(sif.m_valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);

    // line held low for two frames
    f0 = ferr_cnt; b0 = brk_cnt;
    serial = 1'b0; idle(20 * BIT);
    serial = 1'b1; idle(2 * BIT);
    chk("brk_pulse", brk_cnt - b0, BRK_EN);
    chk("brk_ferr", ferr_cnt - f0, 1 - BRK_EN);
    chk("brk_nobyte", got.size(), 0);

    // reset during bit 4 with three bytes queued
    sif.m_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(BIT);
    chk("q3_valid", 32'(sif.m_valid), 1);
    chk("q3_head", 32'(sif.m_data), 32'h11);
    part = 8'h0F;
    serial = 1'b0; idle(BIT);
    for (int i = 0; i < 4; i++) begin serial = part[i]; idle(BIT); end
    serial = part[4]; idle(BIT / 2);
    rst_n = 1'b0; idle(2);
    chk_all_zero("midrst");
    idle(2); rst_n = 1'b1;
    idle(BIT / 2 - 4);
    for (int i = 5; i < 8; i++) begin serial = part[i]; idle(BIT); end
    serial = 1'b1; idle(3 * BIT);
    got.delete();
    sif.m_ready = 1'b1;
    send_byte(8'h7E, 1'b1);
    idle(BIT);
    chk("rst_cnt", got.size(), 1);
    chk("rst_7e", pop_got(), 9'h07E);
    chk("rst_empty", 32'(sif.m_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
